// File: rtl/router_pkt_tx_if.sv
// Signal bundle between a packet source and router_pkt_tx, plus the serial
// frame/valid/data lines toward the router input register.
interface router_pkt_tx_if;
   logic        start;
   logic [3:0]  addr;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        data_last;
   logic        data_ready;
   logic        pkt_din;
   logic        pkt_frame_n;
   logic        pkt_valid_n;
   logic        busy;
   logic [15:0] pkt_count;

   modport master (
      output start, addr, data_in, data_valid, data_last,
      input  data_ready, pkt_din, pkt_frame_n, pkt_valid_n, busy, pkt_count
   );

   modport slave (
      input  start, addr, data_in, data_valid, data_last,
      output data_ready, pkt_din, pkt_frame_n, pkt_valid_n, busy, pkt_count
   );
endinterface

// File: rtl/router_pkt_tx.sv
// Serialises one packet (4-bit address, padding, LSB-first payload bytes) onto
// the router's din/frame_n/valid_n input, buffering one byte ahead of the shifter.
module router_pkt_tx #(
   parameter int unsigned PAD_CYCLES = 5
) (
   input  logic           clk,
   input  logic           reset_n,
   router_pkt_tx_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ADDR, PAD, DATA} state_e;

   localparam logic [3:0] PAD_LAST = 4'(PAD_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  addr_q, addr_d;
   logic [7:0]  sr_q, sr_d;
   logic        sr_valid_q, sr_valid_d;
   logic        sr_last_q, sr_last_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_valid_q, hold_valid_d;
   logic        hold_last_q, hold_last_d;
   logic        last_acc_q, last_acc_d;
   logic [15:0] pkt_count_q, pkt_count_d;

   logic       ready, accept, avail, avail_last, load_sr;
   logic [7:0] avail_byte;
   logic       pad_end, byte_end, pkt_end;
   logic       din, frame_n, valid_n;

   assign ready    = (state_q != IDLE) && !hold_valid_q && !last_acc_q;
   assign accept   = ready && bus.data_valid;
   assign pad_end  = (state_q == PAD) && (cnt_q == PAD_LAST);
   assign byte_end = (state_q == DATA) && sr_valid_q && (cnt_q == 4'd7);
   assign pkt_end  = byte_end && sr_last_q;

   // A byte accepted this cycle can feed the shifter directly when the holding
   // register is empty, so a late byte restarts the stream without an extra gap.
   assign avail      = hold_valid_q || accept;
   assign avail_byte = hold_valid_q ? hold_q : bus.data_in;
   assign avail_last = hold_valid_q ? hold_last_q : bus.data_last;
   assign load_sr    = avail && (pad_end || ((state_q == DATA) &&
                                 (!sr_valid_q || (byte_end && !sr_last_q))));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: each always_comb assigns its outputs a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = ADDR;
         ADDR:    if (cnt_q == 4'd3) state_d = PAD;
         PAD:     if (pad_end) state_d = DATA;
         DATA:    if (pkt_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      din     = 1'b0;
      frame_n = 1'b0;
      valid_n = 1'b1;
      case (state_q)
         IDLE: frame_n = 1'b1;
         ADDR: din = addr_q[cnt_q[1:0]];
         PAD:  din = 1'b1;
         DATA: begin
            if (sr_valid_q) begin
               din     = sr_q[0];
               valid_n = 1'b0;
               frame_n = sr_last_q && (cnt_q == 4'd7);
            end
         end
         default: frame_n = 1'b1;
      endcase
   end

   always_comb begin
      cnt_d        = 4'd0;
      addr_d       = addr_q;
      sr_d         = sr_q;
      sr_valid_d   = sr_valid_q;
      sr_last_d    = sr_last_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      hold_last_d  = hold_last_q;
      last_acc_d   = last_acc_q;
      pkt_count_d  = pkt_count_q;

      case (state_q)
         IDLE: if (bus.start) addr_d = bus.addr;
         ADDR: cnt_d = (cnt_q == 4'd3) ? 4'd0 : cnt_q + 4'd1;
         PAD:  cnt_d = pad_end ? 4'd0 : cnt_q + 4'd1;
         DATA: if (sr_valid_q) cnt_d = byte_end ? 4'd0 : cnt_q + 4'd1;
         default: cnt_d = 4'd0;
      endcase

      if ((state_q == DATA) && sr_valid_q) begin
         sr_d = {1'b0, sr_q[7:1]};
         if (byte_end) sr_valid_d = 1'b0;
      end

      if (load_sr) begin
         sr_d         = avail_byte;
         sr_valid_d   = 1'b1;
         sr_last_d    = avail_last;
         hold_valid_d = 1'b0;
      end else if (accept) begin
         hold_d       = bus.data_in;
         hold_valid_d = 1'b1;
         hold_last_d  = bus.data_last;
      end

      if (accept && bus.data_last) last_acc_d = 1'b1;
      if (pkt_end) begin
         last_acc_d  = 1'b0;
         pkt_count_d = pkt_count_q + 16'd1;
      end
   end

   // Byte registers are cleared on reset too, so an aborted packet leaves no
   // stale payload behind for the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= 4'd0;
         addr_q       <= 4'd0;
         sr_q         <= 8'd0;
         sr_valid_q   <= 1'b0;
         sr_last_q    <= 1'b0;
         hold_q       <= 8'd0;
         hold_valid_q <= 1'b0;
         hold_last_q  <= 1'b0;
         last_acc_q   <= 1'b0;
         pkt_count_q  <= 16'd0;
      end else begin
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         sr_q         <= sr_d;
         sr_valid_q   <= sr_valid_d;
         sr_last_q    <= sr_last_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         hold_last_q  <= hold_last_d;
         last_acc_q   <= last_acc_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

   assign bus.data_ready  = ready;
   assign bus.pkt_din     = din;
   assign bus.pkt_frame_n = frame_n;
   assign bus.pkt_valid_n = valid_n;
   assign bus.busy        = (state_q != IDLE);
   assign bus.pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: address/pad/payload framing, back-to-back
// bytes, underrun gaps, ignored start, mid-packet reset and counter wrap.
module tb_router_pkt_tx;

   localparam int PAD = 5;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   router_pkt_tx_if bus();

   router_pkt_tx #(.PAD_CYCLES(PAD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cycle(input string tag, input logic din, input logic frame_n,
                              input logic valid_n);
      check({tag, ".din"},     32'(bus.pkt_din),     32'(din));
      check({tag, ".frame_n"}, 32'(bus.pkt_frame_n), 32'(frame_n));
      check({tag, ".valid_n"}, 32'(bus.pkt_valid_n), 32'(valid_n));
      step();
   endtask

   task automatic idle_check(input string tag);
      check({tag, ".frame_n"}, 32'(bus.pkt_frame_n), 32'd1);
      check({tag, ".valid_n"}, 32'(bus.pkt_valid_n), 32'd1);
      check({tag, ".din"},     32'(bus.pkt_din),     32'd0);
      check({tag, ".ready"},   32'(bus.data_ready),  32'd0);
      check({tag, ".busy"},    32'(bus.busy),        32'd0);
   endtask

   task automatic addr_pad(input string tag, input logic [3:0] a);
      for (int i = 0; i < 4; i++) check_cycle({tag, ".addr"}, a[i], 1'b0, 1'b1);
      for (int i = 0; i < PAD; i++) check_cycle({tag, ".pad"}, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic byte_bits(input string tag, input logic [7:0] b, input logic last);
      for (int j = 0; j < 8; j++) check_cycle(tag, b[j], last && (j == 7), 1'b0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      bus.data_valid = 1'b1;
      bus.data_in    = b;
      bus.data_last  = last;
      while (!bus.data_ready && n < 64) begin
         step();
         n++;
      end
      check("send.ready", 32'(bus.data_ready), 32'd1);
      step();
      bus.data_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n        = 1'b0;
      bus.start      = 1'b0;
      bus.addr       = 4'h0;
      bus.data_in    = 8'h00;
      bus.data_valid = 1'b0;
      bus.data_last  = 1'b0;
      #2;
      idle_check("in_reset");
      check("in_reset.count", 32'(bus.pkt_count), 32'h0);
      @(negedge clk) reset_n = 1'b1;
      step();
      idle_check("post_reset");

      // Reset in the middle of PAD aborts immediately without counting.
      bus.start = 1'b1;
      bus.addr  = 4'h5;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) check_cycle("rst.addr", (i % 2) == 0, 1'b0, 1'b1);
      check_cycle("rst.pad", 1'b1, 1'b0, 1'b1);
      check_cycle("rst.pad", 1'b1, 1'b0, 1'b1);
      #3 reset_n = 1'b0;
      #1;
      idle_check("rst.async");
      check("rst.async.count", 32'(bus.pkt_count), 32'h0);
      @(negedge clk) reset_n = 1'b1;
      step();
      idle_check("rst.after");

      // Single-byte packet, addr 1011, payload A5; a pulse while not ready is ignored.
      bus.start = 1'b1;
      bus.addr  = 4'b1011;
      step();
      bus.start = 1'b0;
      bus.addr  = 4'h0;
      check("t1.ready", 32'(bus.data_ready), 32'd1);
      check("t1.busy",  32'(bus.busy),       32'd1);
      bus.data_valid = 1'b1;
      bus.data_in    = 8'hA5;
      bus.data_last  = 1'b1;
      check_cycle("t1.addr0", 1'b1, 1'b0, 1'b1);
      bus.data_in   = 8'hFF;
      bus.data_last = 1'b0;
      check("t1.not_ready", 32'(bus.data_ready), 32'd0);
      check_cycle("t1.addr1", 1'b1, 1'b0, 1'b1);
      bus.data_valid = 1'b0;
      check_cycle("t1.addr2", 1'b0, 1'b0, 1'b1);
      check_cycle("t1.addr3", 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < PAD; i++) check_cycle("t1.pad", 1'b1, 1'b0, 1'b1);
      byte_bits("t1.data", 8'hA5, 1'b1);
      idle_check("t1.end");
      check("t1.count", 32'(bus.pkt_count), 32'd1);

      // Three bytes back-to-back give 24 contiguous valid cycles.
      bus.start = 1'b1;
      bus.addr  = 4'h6;
      step();
      bus.start = 1'b0;
      fork
         begin
            send_byte(8'h01, 1'b0);
            send_byte(8'hFF, 1'b0);
            send_byte(8'h80, 1'b1);
         end
         begin
            addr_pad("t2", 4'h6);
            byte_bits("t2.b0", 8'h01, 1'b0);
            byte_bits("t2.b1", 8'hFF, 1'b0);
            byte_bits("t2.b2", 8'h80, 1'b1);
         end
      join
      idle_check("t2.end");
      check("t2.count", 32'(bus.pkt_count), 32'd2);

      // Late second byte: 5-cycle underrun gap; start during DATA and final bit ignored.
      bus.start = 1'b1;
      bus.addr  = 4'h9;
      step();
      bus.start      = 1'b0;
      bus.data_valid = 1'b1;
      bus.data_in    = 8'h3C;
      bus.data_last  = 1'b0;
      check_cycle("t3.addr0", 1'b1, 1'b0, 1'b1);
      bus.data_valid = 1'b0;
      check_cycle("t3.addr1", 1'b0, 1'b0, 1'b1);
      check_cycle("t3.addr2", 1'b0, 1'b0, 1'b1);
      check_cycle("t3.addr3", 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < PAD; i++) check_cycle("t3.pad", 1'b1, 1'b0, 1'b1);
      for (int j = 0; j < 8; j++) begin
         if (j == 3) begin
            bus.start = 1'b1;
            bus.addr  = 4'h3;
         end
         check_cycle("t3.b0", (8'h3C >> j) & 8'h01, 1'b0, 1'b0);
         bus.start = 1'b0;
      end
      check("t3.busy", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            check("t3.gap.ready", 32'(bus.data_ready), 32'd1);
            bus.data_valid = 1'b1;
            bus.data_in    = 8'hC3;
            bus.data_last  = 1'b1;
         end
         check_cycle("t3.gap", 1'b0, 1'b0, 1'b1);
      end
      bus.data_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         if (j == 7) begin
            bus.start = 1'b1;
            bus.addr  = 4'h3;
         end
         check_cycle("t3.b1", (8'hC3 >> j) & 8'h01, j == 7, 1'b0);
      end
      bus.start = 1'b0;
      idle_check("t3.end");
      check("t3.count", 32'(bus.pkt_count), 32'd3);
      step();
      check("t3.still_idle", 32'(bus.busy), 32'd0);

      // Counter wraps from FFFF to 0000.
      force dut.pkt_count_q = 16'hFFFF;
      step();
      release dut.pkt_count_q;
      step();
      check("t6.preset", 32'(bus.pkt_count), 32'hFFFF);
      bus.start = 1'b1;
      bus.addr  = 4'hF;
      step();
      bus.start      = 1'b0;
      bus.data_valid = 1'b1;
      bus.data_in    = 8'h00;
      bus.data_last  = 1'b1;
      check_cycle("t6.addr0", 1'b1, 1'b0, 1'b1);
      bus.data_valid = 1'b0;
      for (int i = 1; i < 4; i++) check_cycle("t6.addr", 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < PAD; i++) check_cycle("t6.pad", 1'b1, 1'b0, 1'b1);
      byte_bits("t6.data", 8'h00, 1'b1);
      idle_check("t6.end");
      check("t6.count", 32'(bus.pkt_count), 32'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 Parameter PAD_CYCLES, default 5, number of padding cycles between address and payload; the block SHALL support values 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset; the block SHALL treat it as asynchronous and active-low.
REQ-004 start  input  1  packet request; the block SHALL sample it together with addr only when busy=0.
REQ-005 addr  input  4  destination port; the block SHALL latch it when start is accepted.
REQ-006 data_in  input  8  payload byte.
REQ-007 data_valid  input  1  data_in is valid; the block SHALL accept a byte when data_valid=1 and data_ready=1.
REQ-008 data_last  input  1  marks the final byte of the packet; the block SHALL sample it with the accepted byte.
REQ-009 data_ready  output  1  the block SHALL drive it high when it can accept a byte this cycle.
REQ-010 pkt_din  output  1  serial bit to the router input register.
REQ-011 pkt_frame_n  output  1  active-low frame to the router input register.
REQ-012 pkt_valid_n  output  1  active-low payload-valid to the router input register.
REQ-013 busy  output  1  the block SHALL drive it high in any state other than IDLE.
REQ-014 pkt_count  output  16  count of completed packets; the block SHALL wrap it from 0xFFFF to 0x0000.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, PAD, DATA.
REQ-016 IDLE outputs SHALL be pkt_frame_n=1, pkt_valid_n=1, pkt_din=0, data_ready=0.
REQ-017 When start=1 in IDLE, the block SHALL latch addr and enter ADDR on the next edge; start SHALL be ignored while busy=1.
REQ-018 ADDR SHALL last exactly 4 cycles with pkt_frame_n=0, pkt_valid_n=1 and pkt_din=addr[0],addr[1],addr[2],addr[3], LSB first.
REQ-019 PAD SHALL last exactly PAD_CYCLES cycles with pkt_frame_n=0, pkt_valid_n=1, pkt_din=1.
REQ-020 The first address bit SHALL appear 1 cycle after start is accepted, and the first payload bit SHALL appear no earlier than 1+4+PAD_CYCLES cycles after start is accepted.
REQ-021 Buffering: the block SHALL use a shift register (current byte) plus a 1-entry holding register; data_ready SHALL equal (state != IDLE) AND (holding register empty) AND (last byte not yet accepted).
REQ-022 DATA with a current byte SHALL shift it LSB first, one bit per cycle, with pkt_valid_n=0 and pkt_frame_n=0.
REQ-023 Bit 7 of a non-last byte: if the holding register is full, the block SHALL load it into the shift register so the next cycle carries bit 0 with no gap.
REQ-024 Underrun (no byte available in DATA): the block SHALL drive pkt_valid_n=1, pkt_frame_n=0, pkt_din=0 until a byte arrives; gaps SHALL occur only on byte boundaries.
REQ-025 Bit 7 of the last byte: the block SHALL drive pkt_frame_n=1 and pkt_valid_n=0, then return to IDLE and increment pkt_count by 1 on the same edge.
REQ-026 A byte accepted while in ADDR or PAD SHALL be held until DATA begins.
REQ-027 Minimum inter-packet gap SHALL be 1 IDLE cycle; start asserted during the final bit SHALL be ignored.
REQ-028 A data_valid pulse while data_ready=0 SHALL be ignored with no state change.

Reset
REQ-029 While reset_n=0, asynchronously: state=IDLE, pkt_frame_n=1, pkt_valid_n=1, pkt_din=0, data_ready=0, busy=0, pkt_count=0, both byte registers empty, latched address cleared.
REQ-030 Reset mid-packet SHALL abort the packet immediately, with no pkt_count increment; the first start after reset_n rises SHALL begin a fresh packet.

Verification
REQ-031 The bench SHALL cover: start with addr=4'b1011 and one byte 0xA5 with last=1 -> pkt_din 1,1,0,1 then 1 x5, then 1,0,1,0,0,1,0,1 with valid_n=0; frame_n high on the final bit; pkt_count=1.
REQ-032 The bench SHALL cover: 3 bytes 0x01,0xFF,0x80 available back-to-back -> 24 contiguous valid_n=0 cycles, no gaps.
REQ-033 The bench SHALL cover: second byte supplied 5 cycles late -> valid_n=1 with frame_n=0 for the gap, then resume at bit 0.
REQ-034 The bench SHALL cover: start pulsed during DATA with addr=4'h3 -> ignored; the current packet completes with its original address.
REQ-035 The bench SHALL cover: reset_n low mid-PAD -> outputs return to idle values in the same cycle; pkt_count unchanged at 0.
REQ-036 The bench SHALL cover: pkt_count forced to 0xFFFF and one packet completed -> pkt_count=0x0000.
